// File: rtl/mmio_responder_if.sv
// CPU-side MMIO bus plus the outbound TX and inbound RX byte streams of the responder.
interface mmio_responder_if;
  logic [7:0] mem_addr_h;
  logic [7:0] mem_addr_l;
  logic       mem_rw;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       hit;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport slave (
    input  mem_addr_h, mem_addr_l, mem_rw, mem_wdata, tx_ready, rx_valid, rx_data,
    output mem_rdata, hit, tx_valid, tx_data, rx_ready
  );
  modport master (
    output mem_addr_h, mem_addr_l, mem_rw, mem_wdata, tx_ready, rx_valid, rx_data,
    input  mem_rdata, hit, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO page with TX/RX byte FIFOs and a prescaled down-counting timer.
// Read data is combinational from registered state; writes fire once per access.
module mmio_responder_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign head_o  = empty_o ? 8'h00 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

module mmio_responder #(
  parameter logic [7:0] BASE_PAGE = 8'hD0,
  parameter int         DEPTH     = 4,
  parameter int         PRESCALE  = 16
) (
  input  logic             clk,
  input  logic             rst,
  mmio_responder_if.slave  bus,
  output logic             irq
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [2:0]    off;
  logic          wr_req, wr_fire;
  logic          armed_q, armed_d;
  logic [2:0]    last_off_q, last_off_d;
  logic [7:0]    reg_we;
  logic [3:0]    cmd;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic          ovr_q, ovr_d, flag_q, flag_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [7:0]    reload_q, reload_d, count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [7:0]    rdata;

  assign off     = bus.mem_addr_l[2:0];
  assign bus.hit = (bus.mem_addr_h == BASE_PAGE) && (bus.mem_addr_l[7:3] == 5'd0);
  assign wr_req  = bus.hit && !bus.mem_rw;
  // A held write stays disarmed until it drops or moves to another register.
  assign wr_fire = wr_req && (armed_q || (off != last_off_q));
  assign reg_we  = wr_fire ? (8'b1 << off) : 8'b0;
  assign cmd     = reg_we[3] ? bus.mem_wdata[3:0] : 4'b0;

  assign armed_d    = !wr_req;
  assign last_off_d = wr_req ? off : last_off_q;

  mmio_responder_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push_i(reg_we[1]), .pop_i(bus.tx_valid && bus.tx_ready),
    .flush_i(cmd[3]), .wdata_i(bus.mem_wdata), .head_o(tx_head),
    .full_o(tx_full), .empty_o(tx_empty)
  );

  mmio_responder_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push_i(bus.rx_valid && bus.rx_ready), .pop_i(cmd[0]),
    .flush_i(cmd[3]), .wdata_i(bus.rx_data), .head_o(rx_head),
    .full_o(rx_full), .empty_o(rx_empty)
  );

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_head;
  assign bus.rx_ready = !rx_full;
  assign tick         = ctrl_q[0] && (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    ovr_d    = ovr_q;
    flag_d   = flag_q;
    ctrl_d   = ctrl_q;
    reload_d = reload_q;
    count_d  = count_q;
    presc_d  = (ctrl_q[0] && !tick) ? presc_q + PW'(1) : '0;
    if (cmd[2]) ovr_d = 1'b0;
    if (reg_we[1] && tx_full) ovr_d = 1'b1;
    if (cmd[1]) flag_d = 1'b0;
    // A reload write on a tick edge replaces the tick entirely.
    if (tick && !reg_we[4]) begin
      if (count_q != 8'd0) begin
        count_d = count_q - 8'd1;
      end else begin
        flag_d = 1'b1;
        if (ctrl_q[1]) count_d = reload_q;
        else           ctrl_d[0] = 1'b0;
      end
    end
    if (reg_we[4]) begin
      reload_d = bus.mem_wdata;
      count_d  = bus.mem_wdata;
      presc_d  = '0;
    end
    if (reg_we[6]) ctrl_d = bus.mem_wdata[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q    <= 1'b1;
      last_off_q <= 3'd0;
      ovr_q      <= 1'b0;
      flag_q     <= 1'b0;
      ctrl_q     <= 4'd0;
      reload_q   <= 8'd0;
      count_q    <= 8'd0;
      presc_q    <= '0;
    end else begin
      armed_q    <= armed_d;
      last_off_q <= last_off_d;
      ovr_q      <= ovr_d;
      flag_q     <= flag_d;
      ctrl_q     <= ctrl_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      presc_q    <= presc_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (off)
      3'd0:    rdata = {2'b00, ovr_q, flag_q, rx_full, !rx_empty, tx_empty, tx_full};
      3'd2:    rdata = rx_head;
      3'd4:    rdata = reload_q;
      3'd5:    rdata = count_q;
      3'd6:    rdata = {4'b0000, ctrl_q};
      default: rdata = 8'h00;
    endcase
  end

  assign bus.mem_rdata = (bus.hit && bus.mem_rw) ? rdata : 8'h00;
  assign irq           = (flag_q && ctrl_q[2]) || (!rx_empty && ctrl_q[3]);
endmodule
